// File: rtl/mmio_pkg.sv
// Shared constants and region decode for the MIPS150 memory-map / I/O controller.
// Region nibble patterns and I/O register offsets live here so the top and tests agree.
package mmio_pkg;

   localparam logic [3:0] REGION_IO = 4'b1000;

   localparam logic [7:0] TX_STAT = 8'h00;
   localparam logic [7:0] RX_STAT = 8'h04;
   localparam logic [7:0] TX_DATA = 8'h08;
   localparam logic [7:0] RX_DATA = 8'h0C;
   localparam logic [7:0] CYC_CNT = 8'h10;
   localparam logic [7:0] INS_CNT = 8'h14;
   localparam logic [7:0] CNT_CLR = 8'h18;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_DMEM,
      REG_IMEM,
      REG_DMEM_IMEM,
      REG_IO
   } region_e;

   // DMEM is 0xx1, IMEM is 0x1x; an address matching both selects both memories.
   function automatic region_e decode_region(input logic [3:0] nib);
      region_e r;
      r = REG_NONE;
      if (nib == REGION_IO)
         r = REG_IO;
      else if (!nib[3] && nib[0] && nib[1])
         r = REG_DMEM_IMEM;
      else if (!nib[3] && nib[0])
         r = REG_DMEM;
      else if (!nib[3] && nib[1])
         r = REG_IMEM;
      return r;
   endfunction

endpackage

// File: rtl/mmio_rx_fifo.sv
// Small synchronous FIFO for UART receive bytes; head is visible without a pop.
// Count carries one extra bit so a full FIFO is distinguishable from an empty one.
module mmio_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign full   = (r_count == (AW+1)'(DEPTH));
   assign empty  = (r_count == '0);
   assign head   = r_mem[r_rd_ptr];
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-map and I/O controller: store-mask steering, I/O read mux, UART TX/RX buffering.
// Define MMIO_COUNTERS_EN to build the cycle / retired-instruction counters (0x10/0x14/0x18).
module mmio_io_ctrl
   import mmio_pkg::*;
#(
   parameter int RX_DEPTH = 4,
   parameter int CNT_W    = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [3:0]  store_mask_in,
   input  logic [31:0] store_data,
   input  logic        is_load,
   input  logic        instr_retire,
   output logic [3:0]  store_mask_dmem,
   output logic [3:0]  store_mask_imem,
   output logic        load_dmem_or_io,
   output logic [31:0] io_rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   region_e    w_region;
   logic       w_is_io;
   logic [7:0] w_off;
   logic       w_io_wr;
   logic       w_wr_tx;
   logic       w_pop;
   logic       w_full;
   logic       w_empty;
   logic [7:0] w_head;
   logic [7:0] r_tx_data;
   logic       r_tx_valid;

   assign w_region = decode_region(addr[31:28]);
   assign w_is_io  = (w_region == REG_IO);
   assign w_off    = addr[7:0];
   assign w_io_wr  = w_is_io & (store_mask_in == 4'b1111);
   assign w_wr_tx  = w_io_wr & (w_off == TX_DATA);
   assign w_pop    = is_load & w_is_io & (w_off == RX_DATA);

   assign store_mask_dmem = (w_region == REG_DMEM || w_region == REG_DMEM_IMEM) ? store_mask_in : 4'b0000;
   assign store_mask_imem = (w_region == REG_IMEM || w_region == REG_DMEM_IMEM) ? store_mask_in : 4'b0000;
   assign load_dmem_or_io = is_load & w_is_io;

   // A new byte may replace one the transmitter is taking this very cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_valid <= 1'b0;
         r_tx_data  <= 8'h00;
      end else if (w_wr_tx && (!r_tx_valid || tx_ready)) begin
         r_tx_valid <= 1'b1;
         r_tx_data  <= store_data[7:0];
      end else if (r_tx_valid && tx_ready) begin
         r_tx_valid <= 1'b0;
      end
   end

   assign tx_valid = r_tx_valid;
   assign tx_data  = r_tx_data;
   assign rx_ready = ~w_full;

   mmio_rx_fifo #(
      .DEPTH (RX_DEPTH),
      .W     (8)
   ) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_valid & ~w_full),
      .pop   (w_pop),
      .wdata (rx_data),
      .full  (w_full),
      .empty (w_empty),
      .head  (w_head)
   );

`ifdef MMIO_COUNTERS_EN
   logic [CNT_W-1:0] r_cyc_cnt;
   logic [CNT_W-1:0] r_ins_cnt;
   logic             w_clr;

   assign w_clr = w_io_wr & (w_off == CNT_CLR);

   always_ff @(posedge clk) begin
      if (rst || w_clr) begin
         r_cyc_cnt <= '0;
         r_ins_cnt <= '0;
      end else begin
         r_cyc_cnt <= r_cyc_cnt + 1'b1;
         r_ins_cnt <= r_ins_cnt + CNT_W'(instr_retire);
      end
   end
`else
   logic w_unused_cnt;
   assign w_unused_cnt = instr_retire;
`endif

   logic w_unused;
   assign w_unused = &{1'b0, store_data[31:8], addr[27:8]};

   always_comb begin
      io_rdata = 32'h0;
      if (w_is_io) begin
         case (w_off)
            TX_STAT: io_rdata[0] = ~r_tx_valid;
            RX_STAT: io_rdata[0] = ~w_empty;
            RX_DATA: io_rdata    = w_empty ? 32'h0 : {24'h0, w_head};
`ifdef MMIO_COUNTERS_EN
            CYC_CNT: io_rdata    = 32'(r_cyc_cnt);
            INS_CNT: io_rdata    = 32'(r_ins_cnt);
`endif
            default: io_rdata    = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl: store steering, UART TX/RX, counters, mid-run reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
module tb_mmio_io_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [3:0]  store_mask_in;
   logic [31:0] store_data;
   logic        is_load;
   logic        instr_retire;
   logic [3:0]  store_mask_dmem;
   logic [3:0]  store_mask_imem;
   logic        load_dmem_or_io;
   logic [31:0] io_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mmio_io_ctrl #(.RX_DEPTH(4), .CNT_W(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .addr            (addr),
      .store_mask_in   (store_mask_in),
      .store_data      (store_data),
      .is_load         (is_load),
      .instr_retire    (instr_retire),
      .store_mask_dmem (store_mask_dmem),
      .store_mask_imem (store_mask_imem),
      .load_dmem_or_io (load_dmem_or_io),
      .io_rdata        (io_rdata),
      .tx_data         (tx_data),
      .tx_valid        (tx_valid),
      .tx_ready        (tx_ready),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .rx_ready        (rx_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: 0x%08h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      addr          = 32'h0000_0000;
      store_mask_in = 4'b0000;
      store_data    = 32'h0;
      is_load       = 1'b0;
      instr_retire  = 1'b0;
      rx_valid      = 1'b0;
      rx_data       = 8'h00;
   endtask

   // Combinational I/O read of one offset, no pop unless it is RX_DATA with is_load.
   task automatic peek(input logic [31:0] a, input string tag, input logic [31:0] exp);
      addr    = a;
      is_load = 1'b0;
      #1;
      check(tag, io_rdata, exp);
      addr    = 32'h0;
   endtask

   task automatic sw(input logic [31:0] a, input logic [31:0] d);
      addr          = a;
      store_mask_in = 4'b1111;
      store_data    = d;
      tick();
      idle();
   endtask

   task automatic push(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      tx_ready = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("rst_tx_data", {24'h0, tx_data}, 32'h0);
      check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
      peek(32'h8000_0004, "rst_rx_stat", 32'h0);
      peek(32'h8000_0000, "rst_tx_stat", 32'h1);

`ifdef MMIO_COUNTERS_EN
      repeat (10) tick();
      peek(32'h8000_0010, "cyc_after_10", 32'd10);
      instr_retire = 1'b1;
      repeat (3) tick();
      instr_retire = 1'b0;
      peek(32'h8000_0014, "ins_after_3", 32'd3);
      addr          = 32'h8000_0018;
      store_mask_in = 4'b1111;
      instr_retire  = 1'b1;
      tick();
      idle();
      peek(32'h8000_0010, "cyc_cleared", 32'd0);
      peek(32'h8000_0014, "ins_cleared", 32'd0);
`else
      tick();
      peek(32'h8000_0010, "cyc_absent", 32'd0);
      peek(32'h8000_0014, "ins_absent", 32'd0);
`endif

      // store steering
      addr = 32'h1000_0004; store_mask_in = 4'b1111; #1;
      check("dmem_only_d", {28'h0, store_mask_dmem}, 32'hF);
      check("dmem_only_i", {28'h0, store_mask_imem}, 32'h0);
      addr = 32'h3000_0008; store_mask_in = 4'b0011; #1;
      check("both_d", {28'h0, store_mask_dmem}, 32'h3);
      check("both_i", {28'h0, store_mask_imem}, 32'h3);
      addr = 32'h8000_0008; store_mask_in = 4'b0011; store_data = 32'h99; #1;
      check("io_d", {28'h0, store_mask_dmem}, 32'h0);
      check("io_i", {28'h0, store_mask_imem}, 32'h0);
      tick();
      idle();
      check("partial_io_wr_ignored", {31'h0, tx_valid}, 32'h0);
      addr = 32'hC000_000C; is_load = 1'b1; #1;
      check("unmapped_lsel", {31'h0, load_dmem_or_io}, 32'h0);
      check("unmapped_rdata", io_rdata, 32'h0);
      idle();

      // TX holding register
      sw(32'h8000_0008, 32'h0000_0041);
      check("tx_load_valid", {31'h0, tx_valid}, 32'h1);
      check("tx_load_data", {24'h0, tx_data}, 32'h41);
      peek(32'h8000_0000, "tx_stat_busy", 32'h0);
      sw(32'h8000_0008, 32'h0000_0042);
      check("tx_drop_data", {24'h0, tx_data}, 32'h41);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      check("tx_sent_valid", {31'h0, tx_valid}, 32'h0);
      peek(32'h8000_0000, "tx_stat_idle", 32'h1);
      sw(32'h8000_0008, 32'h0000_0055);
      tx_ready = 1'b1;
      sw(32'h8000_0008, 32'h0000_0066);
      check("tx_backtoback_valid", {31'h0, tx_valid}, 32'h1);
      check("tx_backtoback_data", {24'h0, tx_data}, 32'h66);
      tick();
      tx_ready = 1'b0;
      check("tx_drain_valid", {31'h0, tx_valid}, 32'h0);

      // RX FIFO fill, overflow attempt, drain, underflow attempt
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      check("rx_full_ready", {31'h0, rx_ready}, 32'h0);
      push(8'h55);
      peek(32'h8000_0004, "rx_stat_full", 32'h1);
      addr = 32'h8000_000C; is_load = 1'b1; #1;
      check("rx_pop0_data", io_rdata, 32'h11);
      check("rx_pop0_lsel", {31'h0, load_dmem_or_io}, 32'h1);
      tick();
      check("rx_after_pop_ready", {31'h0, rx_ready}, 32'h1);
      check("rx_pop1_data", io_rdata, 32'h22);
      tick();
      check("rx_pop2_data", io_rdata, 32'h33);
      tick();
      check("rx_pop3_data", io_rdata, 32'h44);
      tick();
      check("rx_empty_data", io_rdata, 32'h0);
      tick();
      idle();
      peek(32'h8000_0004, "rx_stat_empty", 32'h0);
      push(8'h77);
      addr = 32'h8000_000C; is_load = 1'b1; #1;
      check("rx_no_underflow", io_rdata, 32'h77);
      tick();
      idle();

      // simultaneous push and pop with two entries
      push(8'hA1); push(8'hA2);
      addr = 32'h8000_000C; is_load = 1'b1; rx_valid = 1'b1; rx_data = 8'hA3; #1;
      check("sim_head", io_rdata, 32'hA1);
      tick();
      rx_valid = 1'b0; #1;
      check("sim_next", io_rdata, 32'hA2);
      tick();
      check("sim_last", io_rdata, 32'hA3);
      tick();
      idle();
      peek(32'h8000_0004, "sim_count_two", 32'h0);

      // reset in the middle of activity
      sw(32'h8000_0008, 32'h0000_005A);
      push(8'h01); push(8'h02); push(8'h03);
      check("pre_rst_tx_valid", {31'h0, tx_valid}, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("mid_rst_tx_data", {24'h0, tx_data}, 32'h0);
      check("mid_rst_rx_ready", {31'h0, rx_ready}, 32'h1);
      peek(32'h8000_0004, "mid_rst_rx_stat", 32'h0);
`ifdef MMIO_COUNTERS_EN
      peek(32'h8000_0010, "mid_rst_cyc", 32'h0);
      peek(32'h8000_0014, "mid_rst_ins", 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
